// File: rtl/fpdlink_pkg.sv
// Shared constants, types and helpers for the FPD-Link I 1:7 transmit path.
// Lane words use bit 6 as the first serial bit, matching the per-lane receiver.
package fpdlink_pkg;

    localparam logic [6:0] CLK_PATTERN = 7'b1100011;

    localparam int MAP_VESA  = 0;
    localparam int MAP_JEIDA = 1;

    // x^7 + x^6 + 1 : feedback from the two most significant state bits
    localparam logic [6:0] PRBS7_TAPS = 7'b1100000;
    localparam logic [6:0] PRBS7_SEED = 7'h7F;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hs;
        logic       vs;
        logic       de;
    } pixel_t;

    typedef struct packed {
        logic [6:0] l3;
        logic [6:0] l2;
        logic [6:0] l1;
        logic [6:0] l0;
    } lanes_t;

    function automatic lanes_t map_vesa(input pixel_t p);
        lanes_t l;
        l.l0 = {p.g[2], p.r[7:2]};
        l.l1 = {p.b[3:2], p.g[7:3]};
        l.l2 = {p.de, p.vs, p.hs, p.b[7:4]};
        l.l3 = {1'b0, p.b[1:0], p.g[1:0], p.r[1:0]};
        return l;
    endfunction

    function automatic lanes_t map_jeida(input pixel_t p);
        lanes_t l;
        l.l0 = {p.g[0], p.r[5:0]};
        l.l1 = {p.b[1:0], p.g[5:1]};
        l.l2 = {p.de, p.vs, p.hs, p.b[5:2]};
        l.l3 = {1'b0, p.b[7:6], p.g[7:6], p.r[7:6]};
        return l;
    endfunction

    // Advance the LFSR by seven bits; the resulting state holds the seven new
    // bits with the earliest one in bit 6.
    function automatic logic [6:0] prbs7_next(input logic [6:0] s);
        logic [6:0] t;
        t = s;
        for (int unsigned i = 0; i < 7; i++) begin
            t = {t[5:0], ^(t & PRBS7_TAPS)};
        end
        return t;
    endfunction

    function automatic logic [6:0] rotl7(input logic [6:0] v, input int unsigned k);
        logic [6:0] t;
        t = v;
        for (int unsigned i = 0; i < (k % 7); i++) begin
            t = {t[5:0], t[6]};
        end
        return t;
    endfunction

endpackage

// File: rtl/fpdlink_prbs7.sv
// 7-bit-per-cycle parallel PRBS7 generator; output word is the current state.
module fpdlink_prbs7
    import fpdlink_pkg::*;
#(
    parameter logic [6:0] SEED = PRBS7_SEED
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [6:0] word
);

    logic [6:0] state;

    // Step seven bits per enabled cycle, restarting from the seed on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else if (en) begin
            state <= prbs7_next(state);
        end
    end

    assign word = state;

endmodule

// File: rtl/fpdlink_tx_packer.sv
// FPD-Link I 1:7 transmitter front end: pixel handshake, underflow fill,
// pixel-to-lane mapping (VESA/JEIDA) and fixed clock-lane word.
// Optional PRBS7 link-test source is built when FPDLINK_TX_PRBS_EN is defined.
module fpdlink_tx_packer
    import fpdlink_pkg::*;
#(
    parameter int MAPPING  = 0,
    parameter int UF_CNT_W = 16
) (
    input  logic                gclk,
    input  logic                rst,
    input  logic                enable,
    input  logic [7:0]          pix_r,
    input  logic [7:0]          pix_g,
    input  logic [7:0]          pix_b,
    input  logic                pix_hs,
    input  logic                pix_vs,
    input  logic                pix_de,
    input  logic                pix_valid,
    output logic                pix_ready,
    output logic [6:0]          lane0,
    output logic [6:0]          lane1,
    output logic [6:0]          lane2,
    output logic [6:0]          lane3,
    output logic [6:0]          lane_clk,
    output logic [UF_CNT_W-1:0] uf_count,
    output logic                uf_sticky,
    input  logic                uf_clear,
    input  logic                prbs_mode
);

    logic   prbs_active;
    logic   accept;
    logic   underflow;
    logic   hold_hs;
    logic   hold_vs;
    pixel_t s1;
    lanes_t lanes_map;
    lanes_t lanes_next;

`ifdef FPDLINK_TX_PRBS_EN
    logic [6:0] prbs_word [4];
    logic       s1_prbs;

    for (genvar k = 0; k < 4; k++) begin : g_prbs
        fpdlink_prbs7 #(
            .SEED(rotl7(PRBS7_SEED, k))
        ) u_prbs (
            .clk  (gclk),
            .rst  (rst),
            .en   (prbs_mode),
            .word (prbs_word[k])
        );
    end

    assign prbs_active = prbs_mode;

    // Track PRBS mode alongside stage 1 so the generator words take the pixel slot
    always_ff @(posedge gclk) begin
        if (rst) begin
            s1_prbs <= 1'b0;
        end else begin
            s1_prbs <= prbs_mode;
        end
    end
`else
    logic unused_prbs_mode;
    assign unused_prbs_mode = prbs_mode;
    assign prbs_active      = 1'b0;
`endif

    assign pix_ready = enable & ~rst & ~prbs_active;
    assign accept    = pix_valid & pix_ready;
    assign underflow = enable & ~pix_valid & ~prbs_active;

    // Stage 1: register the accepted pixel, or a blanking word holding last HS/VS
    always_ff @(posedge gclk) begin
        if (rst) begin
            s1      <= '0;
            hold_hs <= 1'b0;
            hold_vs <= 1'b0;
        end else if (accept) begin
            s1      <= '{r: pix_r, g: pix_g, b: pix_b, hs: pix_hs, vs: pix_vs, de: pix_de};
            hold_hs <= pix_hs;
            hold_vs <= pix_vs;
        end else begin
            s1      <= '{r: '0, g: '0, b: '0, hs: hold_hs, vs: hold_vs, de: 1'b0};
        end
    end

    // Saturating underflow counter and sticky flag; clear wins over increment
    always_ff @(posedge gclk) begin
        if (rst || uf_clear) begin
            uf_count  <= '0;
            uf_sticky <= 1'b0;
        end else if (underflow) begin
            if (uf_count != '1) begin
                uf_count <= uf_count + 1'b1;
            end
            uf_sticky <= 1'b1;
        end
    end

    // Select the pixel-to-lane map, with PRBS words overriding when active
    always_comb begin
        lanes_map  = (MAPPING == MAP_JEIDA) ? map_jeida(s1) : map_vesa(s1);
        lanes_next = lanes_map;
`ifdef FPDLINK_TX_PRBS_EN
        if (s1_prbs) begin
            lanes_next = '{l3: prbs_word[3], l2: prbs_word[2], l1: prbs_word[1], l0: prbs_word[0]};
        end
`endif
    end

    // Stage 2: registered lane words and constant clock-lane pattern
    always_ff @(posedge gclk) begin
        if (rst) begin
            lane0    <= '0;
            lane1    <= '0;
            lane2    <= '0;
            lane3    <= '0;
            lane_clk <= '0;
        end else begin
            lane0    <= lanes_next.l0;
            lane1    <= lanes_next.l1;
            lane2    <= lanes_next.l2;
            lane3    <= lanes_next.l3;
            lane_clk <= CLK_PATTERN;
        end
    end

endmodule

// File: tb/tb_fpdlink_tx_packer.sv
// Self-checking bench for fpdlink_tx_packer: VESA and JEIDA instances share
// stimulus; expected stage-1 words are queued per edge and checked two edges on.
module tb_fpdlink_tx_packer;

    logic gclk = 1'b0;
    always #5 gclk = ~gclk;

    logic       rst, enable, pix_valid, pix_hs, pix_vs, pix_de, uf_clear, prbs_mode;
    logic [7:0] pix_r, pix_g, pix_b;

    logic        v_ready, j_ready, v_st, j_st;
    logic [6:0]  v_l0, v_l1, v_l2, v_l3, v_clk;
    logic [6:0]  j_l0, j_l1, j_l2, j_l3, j_clk;
    logic [15:0] v_uf, j_uf;

    fpdlink_tx_packer #(.MAPPING(0), .UF_CNT_W(16)) dut_v (
        .gclk(gclk), .rst(rst), .enable(enable),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .pix_hs(pix_hs), .pix_vs(pix_vs), .pix_de(pix_de),
        .pix_valid(pix_valid), .pix_ready(v_ready),
        .lane0(v_l0), .lane1(v_l1), .lane2(v_l2), .lane3(v_l3), .lane_clk(v_clk),
        .uf_count(v_uf), .uf_sticky(v_st), .uf_clear(uf_clear), .prbs_mode(prbs_mode)
    );

    fpdlink_tx_packer #(.MAPPING(1), .UF_CNT_W(16)) dut_j (
        .gclk(gclk), .rst(rst), .enable(enable),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .pix_hs(pix_hs), .pix_vs(pix_vs), .pix_de(pix_de),
        .pix_valid(pix_valid), .pix_ready(j_ready),
        .lane0(j_l0), .lane1(j_l1), .lane2(j_l2), .lane3(j_l3), .lane_clk(j_clk),
        .uf_count(j_uf), .uf_sticky(j_st), .uf_clear(uf_clear), .prbs_mode(prbs_mode)
    );

    typedef struct packed {
        logic       prbs;
        logic [6:0] pw;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hs;
        logic       vs;
        logic       de;
    } exp_t;

    exp_t        q[$];
    int          n_cmp    = 0;
    int          n_bad    = 0;
    int          prbs_err = 0;
    logic        m_hs, m_vs, m_st;
    logic [15:0] m_uf;
    logic [6:0]  m_ps;

    // Lane words per the VESA table, packed {lane3,lane2,lane1,lane0}
    function automatic logic [27:0] vesa(input logic [7:0] r, input logic [7:0] g,
                                         input logic [7:0] b, input logic hs,
                                         input logic vs, input logic de);
        logic [6:0] a0, a1, a2, a3;
        a0 = {g[2], r[7], r[6], r[5], r[4], r[3], r[2]};
        a1 = {b[3], b[2], g[7], g[6], g[5], g[4], g[3]};
        a2 = {de, vs, hs, b[7], b[6], b[5], b[4]};
        a3 = {1'b0, b[1], b[0], g[1], g[0], r[1], r[0]};
        return {a3, a2, a1, a0};
    endfunction

    // JEIDA swaps MSB and LSB pairs: equals VESA applied to each colour rotated by two
    function automatic logic [7:0] rot2(input logic [7:0] c);
        return {c[5:0], c[7:6]};
    endfunction

    function automatic logic prbs_eff();
`ifdef FPDLINK_TX_PRBS_EN
        return prbs_mode;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic valid, input logic [7:0] r, input logic [7:0] g,
                         input logic [7:0] b, input logic hs, input logic vs, input logic de);
        pix_valid = valid;
        pix_r = r; pix_g = g; pix_b = b;
        pix_hs = hs; pix_vs = vs; pix_de = de;
    endtask

    // One clock: update model at the edge, then check outputs 1 time unit later
    task automatic step();
        exp_t        e;
        logic [27:0] ev, ej;
        logic        pe, bit_n;
        @(posedge gclk);
        pe = prbs_eff();
        if (rst) begin
            q.delete();
            q.push_back('0);
            m_hs = 1'b0; m_vs = 1'b0; m_st = 1'b0; m_uf = '0; m_ps = 7'h7F;
        end else begin
            e = '0;
            if (pe) begin
                e.prbs = 1'b1;
                for (int i = 0; i < 7; i++) begin
                    bit_n = m_ps[6] ^ m_ps[5];
                    m_ps  = {m_ps[5:0], bit_n};
                    e.pw[6-i] = bit_n;
                end
            end
            if (pix_valid && enable && !pe) begin
                e.r = pix_r; e.g = pix_g; e.b = pix_b;
                e.hs = pix_hs; e.vs = pix_vs; e.de = pix_de;
                m_hs = pix_hs; m_vs = pix_vs;
            end else begin
                e.hs = m_hs; e.vs = m_vs;
            end
            if (uf_clear) begin
                m_uf = '0; m_st = 1'b0;
            end else if (enable && !pix_valid && !pe) begin
                if (m_uf != 16'hFFFF) m_uf = m_uf + 16'd1;
                m_st = 1'b1;
            end
            q.push_back(e);
        end
        #1;
        if (rst) begin
            chk("rst_lanes_v", {v_l3, v_l2, v_l1, v_l0}, '0);
            chk("rst_lanes_j", {j_l3, j_l2, j_l1, j_l0}, '0);
            chk("rst_clk", {v_clk, j_clk}, '0);
            chk("rst_uf", {v_uf, j_uf, v_st, j_st}, '0);
            chk("rst_ready", {v_ready, j_ready}, '0);
        end else begin
            if (q.size() < 2) begin
                chk("queue_depth", q.size(), 2);
            end else begin
                e = q.pop_front();
                if (e.prbs) begin
                    chk("prbs_v", {v_l3, v_l2, v_l1, v_l0}, {4{e.pw}});
                    chk("prbs_j", {j_l3, j_l2, j_l1, j_l0}, {4{e.pw}});
                    if (v_l0 !== e.pw) prbs_err++;
                end else begin
                    ev = vesa(e.r, e.g, e.b, e.hs, e.vs, e.de);
                    ej = vesa(rot2(e.r), rot2(e.g), rot2(e.b), e.hs, e.vs, e.de);
                    chk("lanes_vesa", {v_l3, v_l2, v_l1, v_l0}, ev);
                    chk("lanes_jeida", {j_l3, j_l2, j_l1, j_l0}, ej);
                end
            end
            chk("lane_clk_v", v_clk, 7'b1100011);
            chk("lane_clk_j", j_clk, 7'b1100011);
            chk("uf_count_v", v_uf, m_uf);
            chk("uf_count_j", j_uf, m_uf);
            chk("uf_sticky", {v_st, j_st}, {m_st, m_st});
            chk("pix_ready", {v_ready, j_ready}, {2{enable & ~pe}});
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; uf_clear = 1'b0; prbs_mode = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        m_hs = 1'b0; m_vs = 1'b0; m_st = 1'b0; m_uf = '0; m_ps = 7'h7F;
        step(); step();
        rst = 1'b0;
        step();

        // Reference pixel streamed continuously
        enable = 1'b1;
        drive(1'b1, 8'hA5, 8'h3C, 8'hF0, 1'b0, 1'b0, 1'b1);
        repeat (5) step();

        // Assorted pixels for both maps
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 8'($urandom), 8'($urandom), 8'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
            step();
        end
        drive(1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
        step();
        drive(1'b1, 8'h81, 8'h42, 8'h24, 1'b0, 1'b0, 1'b1);
        step();

        // Underflow with HS held high, then clear alongside another underflow
        drive(1'b1, 8'h12, 8'h34, 8'h56, 1'b1, 1'b0, 1'b1);
        step();
        uf_clear = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        step();
        uf_clear = 1'b0;
        repeat (3) step();
        chk("uf_after_3", v_uf, 16'd3);
        uf_clear = 1'b1;
        step();
        uf_clear = 1'b0;
        chk("uf_cleared", {v_uf, v_st}, 17'd0);

        // Pixels drain then blanking while disabled; not counted as underflow
        drive(1'b1, 8'h5A, 8'hC3, 8'h0F, 1'b0, 1'b1, 1'b1);
        step();
        enable = 1'b0;
        repeat (4) step();
        pix_valid = 1'b0;
        repeat (2) step();
        enable = 1'b1;

        // PRBS request: ignored unless the generator is built
        prbs_mode = 1'b1;
        drive(1'b1, 8'hC6, 8'h39, 8'h7E, 1'b0, 1'b1, 1'b1);
        repeat (4) step();
        prbs_mode = 1'b0;
        repeat (3) step();

        // Long underflow run to saturate the counter
        uf_clear = 1'b1;
        pix_valid = 1'b0;
        step();
        uf_clear = 1'b0;
        repeat (70000) step();
        chk("uf_saturated", v_uf, 16'hFFFF);

        // Reset mid-stream
        drive(1'b1, 8'h99, 8'h66, 8'h33, 1'b1, 1'b1, 1'b1);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b1, 8'h01, 8'h80, 8'h7F, 1'b0, 1'b1, 1'b1);
        repeat (4) step();

`ifdef FPDLINK_TX_PRBS_EN
        prbs_mode = 1'b1;
        repeat (1000) step();
        prbs_mode = 1'b0;
        repeat (3) step();
        chk("prbs_errors", prbs_err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
